// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/ready flow control,
// flush, optional skid entry and a saturating stall counter.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous kill of all held entries
//   ex_valid/ready  upstream handshake (EX side)
//   ex_wd..ex_lo    incoming GPR and HI/LO write-back payload
//   mem_valid/ready downstream handshake (MEM side)
//   mem_wd..mem_lo  payload of the main (visible) entry
//   stall_cnt       saturating count of mem_valid & !mem_ready
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_whilo,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [REG_AW-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_whilo,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = REG_AW + 2 + 3 * DATA_W;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    SKID_FULL = 2'd2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic [PW-1:0] in_pay;
  logic          rdy_q;
  logic          in_xfer;
  logic          out_xfer;
  logic          ld_in;
  logic          ld_skid;
  logic          pop_skid;
  logic          clr;

  assign in_pay = {ex_wd, ex_wreg, ex_wdata,
                   ex_whilo, ex_hi, ex_lo};

  // Empty main is kept all-zero, so a bubble
  // never carries a write enable into MEM.
  assign {mem_wd, mem_wreg, mem_wdata,
          mem_whilo, mem_hi, mem_lo} = main_q;

  assign mem_valid = (state != EMPTY);
  assign in_xfer   = ex_valid & ex_ready;
  assign out_xfer  = mem_valid & mem_ready;

  // With the skid entry, ready comes straight from a
  // flop so MEM stalls never reach EX combinationally.
  generate
    if (SKID != 0) begin : g_skid
      assign ex_ready = rdy_q;
    end else begin : g_noskid
      assign ex_ready = !mem_valid | mem_ready;
    end
  endgenerate

  always_comb begin
    state_n  = state;
    ld_in    = 1'b0;
    ld_skid  = 1'b0;
    pop_skid = 1'b0;
    clr      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_n = FULL;
          ld_in   = 1'b1;
        end
      end
      FULL: begin
        if (in_xfer && out_xfer) begin
          ld_in = 1'b1;
        end else if (in_xfer) begin
          if (SKID != 0) begin
            state_n = SKID_FULL;
            ld_skid = 1'b1;
          end
        end else if (out_xfer) begin
          state_n = EMPTY;
          clr     = 1'b1;
        end
      end
      SKID_FULL: begin
        if (out_xfer) begin
          state_n  = FULL;
          pop_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      state <= state_n;
      rdy_q <= (state_n != SKID_FULL);
      if (clr) begin
        main_q <= '0;
      end else if (ld_in) begin
        main_q <= in_pay;
      end else if (pop_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= in_pay;
      end else if (pop_skid) begin
        skid_q <= '0;
      end
    end
  end

  // Flush leaves the counter alone; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (mem_valid && !mem_ready &&
                 stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
